// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares the single CPU memory port between the instruction fetch unit (F,
//   read-only) and the execution unit (E, read/write). One transaction is
//   granted at a time and latched into registered memory-side outputs. The
//   memory's completion is steered back to whichever requester owns the bus.
//   F is protected from starvation by a bounded run of E grants, and a
//   transaction that never completes is aborted after TIMEOUT cycles.
//
// Parameters:
//   MAX_WAIT  consecutive E grants allowed while F waits before F is forced
//             (1..15)
//   TIMEOUT   OWN cycles without mem_done before the transaction is aborted;
//             0 disables the timeout
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   f_address/f_datasize/f_read         fetch request (level, held until done)
//   f_done                              one-cycle completion to fetch
//   e_address/e_datasize/e_read/
//   e_write/e_writedata                 exec request (level, held until done)
//   e_done                              one-cycle completion to exec
//   bus_error                           qualifies f_done/e_done: aborted by
//                                       timeout
//   mem_address/mem_datasize/mem_read/
//   mem_write/mem_writedata             registered memory-side request
//   mem_done                            memory completion
//   busy                                a transaction is outstanding
//   grant_e                             current/last owner is E
//
// States:
//   state | meaning
//   IDLE  | no transaction outstanding; requests are sampled and one granted
//   OWN   | a transaction is on the memory port; requester inputs ignored
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [63:0] f_address,
    input  logic [1:0]  f_datasize,
    input  logic        f_read,
    output logic        f_done,

    input  logic [63:0] e_address,
    input  logic [1:0]  e_datasize,
    input  logic        e_read,
    input  logic        e_write,
    input  logic [63:0] e_writedata,
    output logic        e_done,

    output logic        bus_error,

    output logic [63:0] mem_address,
    output logic [1:0]  mem_datasize,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    input  logic        mem_done,

    output logic        busy,
    output logic        grant_e
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [3:0]  WAIT_LIMIT = 4'(MAX_WAIT);
    localparam bit          TMO_EN     = (TIMEOUT != 0);
    // Value of the OWN-cycle counter on the last cycle before abort. The
    // counter is 0 on the first OWN cycle, so this fires on OWN cycle TIMEOUT.
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT - 1);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] tmo_cnt;

    logic e_pend;
    logic f_pend;
    logic pick_f;
    logic tmo_hit;
    logic finish;

    // -------------------------------------------------------------------------
    // Request decode and completion steering
    // -------------------------------------------------------------------------
    always_comb begin
        e_pend = e_read | e_write;
        f_pend = f_read;

        // F wins when it is alone, or when E has used up its run of grants.
        pick_f = f_pend && (!e_pend || (wait_cnt == WAIT_LIMIT));

        // A real mem_done in the timeout cycle is a normal completion.
        tmo_hit = TMO_EN && (state == OWN) && !mem_done && (tmo_cnt == TMO_LAST);

        finish = (state == OWN) && (mem_done || tmo_hit);

        f_done    = finish && !grant_e;
        e_done    = finish && grant_e;
        bus_error = tmo_hit;
    end

    // -------------------------------------------------------------------------
    // Arbiter FSM with registered memory-side outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            tmo_cnt       <= '0;
            mem_address   <= '0;
            mem_datasize  <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            busy          <= 1'b0;
            grant_e       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (e_pend || f_pend) begin
                        state   <= OWN;
                        busy    <= 1'b1;
                        tmo_cnt <= '0;
                        if (pick_f) begin
                            mem_address   <= f_address;
                            mem_datasize  <= f_datasize;
                            mem_writedata <= '0;
                            mem_read      <= 1'b1;
                            mem_write     <= 1'b0;
                            grant_e       <= 1'b0;
                            wait_cnt      <= '0;
                        end else begin
                            mem_address   <= e_address;
                            mem_datasize  <= e_datasize;
                            mem_writedata <= e_writedata;
                            // Read and write together is treated as a write.
                            mem_read      <= e_read && !e_write;
                            mem_write     <= e_write;
                            grant_e       <= 1'b1;
                            if (!f_pend) begin
                                wait_cnt <= '0;
                            end else if (wait_cnt != WAIT_LIMIT) begin
                                wait_cnt <= wait_cnt + 4'd1;
                            end
                        end
                    end
                end

                OWN: begin
                    if (finish) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed scenarios for fetch-only, simultaneous requests, starvation,
// timeout, mid-transaction reset and edge cases, followed by a randomized run
// checked cycle by cycle against a transaction-level model of the arbiter.
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int MAXW = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] f_address;
    logic [1:0]  f_datasize;
    logic        f_read;
    logic        f_done;
    logic [63:0] e_address;
    logic [1:0]  e_datasize;
    logic        e_read;
    logic        e_write;
    logic [63:0] e_writedata;
    logic        e_done;
    logic        bus_error;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic        mem_done;
    logic        busy;
    logic        grant_e;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_arbiter #(.MAX_WAIT(MAXW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_address(f_address), .f_datasize(f_datasize), .f_read(f_read), .f_done(f_done),
        .e_address(e_address), .e_datasize(e_datasize), .e_read(e_read), .e_write(e_write),
        .e_writedata(e_writedata), .e_done(e_done), .bus_error(bus_error),
        .mem_address(mem_address), .mem_datasize(mem_datasize), .mem_read(mem_read),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_done(mem_done),
        .busy(busy), .grant_e(grant_e)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        f_address = '0; f_datasize = '0; f_read = 1'b0;
        e_address = '0; e_datasize = '0; e_read = 1'b0; e_write = 1'b0; e_writedata = '0;
        mem_done = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        step();
        f_read = 1'b1; e_write = 1'b1; mem_done = 1'b1;
        #1;
        n_cmp++; if ({mem_read, mem_write, busy, grant_e, f_done, e_done, bus_error, mem_datasize} !== 9'd0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0", {mem_read, mem_write, busy, grant_e, f_done, e_done, bus_error, mem_datasize}); end
        n_cmp++; if ({mem_address, mem_writedata} !== 128'd0) begin n_bad++; $display("FAIL reset_data: got %h %h want 0", mem_address, mem_writedata); end
        step();
        clear_inputs();
        reset_n = 1'b1;
        step();
        #1;
        n_cmp++; if ({mem_read, mem_write, busy, f_done, e_done} !== 5'd0) begin n_bad++; $display("FAIL reset_idle: got %b want 0", {mem_read, mem_write, busy, f_done, e_done}); end
    endtask

    task automatic test_fetch_only();
        apply_reset();
        f_read = 1'b1; f_address = 64'h8000_0000_0000_0000; f_datasize = 2'd2;
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL fetch_grant_cycle: mem_read got %b want 0", mem_read); end
        step(); #1;
        n_cmp++; if ({mem_read, mem_write, busy, grant_e} !== 4'b1010) begin n_bad++; $display("FAIL fetch_own: got %b want 1010", {mem_read, mem_write, busy, grant_e}); end
        n_cmp++; if (mem_address !== 64'h8000_0000_0000_0000 || mem_datasize !== 2'd2) begin n_bad++; $display("FAIL fetch_addr: got %h/%0d want 8000000000000000/2", mem_address, mem_datasize); end
        step(); #1;
        n_cmp++; if (f_done !== 1'b0) begin n_bad++; $display("FAIL fetch_early_done: got %b want 0", f_done); end
        step();
        mem_done = 1'b1;
        #1;
        n_cmp++; if ({f_done, e_done, bus_error} !== 3'b100) begin n_bad++; $display("FAIL fetch_done: got %b want 100", {f_done, e_done, bus_error}); end
        step();
        f_read = 1'b0; mem_done = 1'b0;
        #1;
        n_cmp++; if ({mem_read, busy, f_done, e_done} !== 4'd0) begin n_bad++; $display("FAIL fetch_release: got %b want 0000", {mem_read, busy, f_done, e_done}); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        f_read = 1'b1; f_address = 64'h1000; f_datasize = 2'd3;
        e_write = 1'b1; e_address = 64'h2000; e_datasize = 2'd2; e_writedata = 64'hDEADBEEF;
        step(); #1;
        n_cmp++; if ({mem_read, mem_write, grant_e} !== 3'b011) begin n_bad++; $display("FAIL simul_e_first: got %b want 011", {mem_read, mem_write, grant_e}); end
        n_cmp++; if (mem_writedata !== 64'hDEADBEEF || mem_address !== 64'h2000) begin n_bad++; $display("FAIL simul_e_data: got %h@%h want deadbeef@2000", mem_writedata, mem_address); end
        step();
        mem_done = 1'b1;
        #1;
        n_cmp++; if ({f_done, e_done} !== 2'b01) begin n_bad++; $display("FAIL simul_e_done: got %b want 01", {f_done, e_done}); end
        step();
        e_write = 1'b0; mem_done = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL simul_idle_gap: busy got %b want 0", busy); end
        step(); #1;
        n_cmp++; if ({mem_read, mem_write, grant_e} !== 3'b100 || mem_address !== 64'h1000 || mem_writedata !== 64'd0) begin n_bad++; $display("FAIL simul_f_next: got %b %h %h want 100 1000 0", {mem_read, mem_write, grant_e}, mem_address, mem_writedata); end
        step();
        mem_done = 1'b1;
        #1;
        n_cmp++; if ({f_done, e_done} !== 2'b10) begin n_bad++; $display("FAIL simul_f_done: got %b want 10", {f_done, e_done}); end
        step();
        f_read = 1'b0; mem_done = 1'b0;
    endtask

    task automatic test_starvation();
        bit exp_e;
        apply_reset();
        f_read = 1'b1; f_address = 64'hF0; e_read = 1'b1; e_address = 64'hE0;
        for (int i = 0; i < 2 * (MAXW + 1); i++) begin
            step();
            mem_done = 1'b1;
            #1;
            exp_e = ((i % (MAXW + 1)) != MAXW);
            n_cmp++; if ({grant_e, e_done, f_done} !== {exp_e, exp_e, !exp_e}) begin n_bad++; $display("FAIL starve_grant%0d: got %b want %b", i, {grant_e, e_done, f_done}, {exp_e, exp_e, !exp_e}); end
            step();
            mem_done = 1'b0;
            if (i == 2 * (MAXW + 1) - 1) begin
                f_read = 1'b0; e_read = 1'b0;
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        e_read = 1'b1; e_address = 64'hABC0; e_datasize = 2'd3;
        step();
        for (int k = 1; k <= TMO; k++) begin
            if (k > 1) step();
            #1;
            n_cmp++; if ({e_done, bus_error, f_done, mem_read} !== {(k == TMO), (k == TMO), 1'b0, 1'b1}) begin n_bad++; $display("FAIL timeout_cycle%0d: got %b want %b", k, {e_done, bus_error, f_done, mem_read}, {(k == TMO), (k == TMO), 1'b0, 1'b1}); end
        end
        step();
        e_read = 1'b0;
        f_read = 1'b1; f_address = 64'h5550; f_datasize = 2'd1;
        #1;
        n_cmp++; if ({mem_read, busy, e_done, bus_error} !== 4'd0) begin n_bad++; $display("FAIL timeout_release: got %b want 0000", {mem_read, busy, e_done, bus_error}); end
        step(); #1;
        n_cmp++; if ({mem_read, grant_e} !== 2'b10 || mem_address !== 64'h5550) begin n_bad++; $display("FAIL timeout_f_grant: got %b %h want 10 5550", {mem_read, grant_e}, mem_address); end
        step();
        mem_done = 1'b1;
        #1;
        n_cmp++; if ({f_done, bus_error} !== 2'b10) begin n_bad++; $display("FAIL timeout_f_done: got %b want 10", {f_done, bus_error}); end
        step();
        f_read = 1'b0; mem_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        e_write = 1'b1; e_address = 64'h7770; e_writedata = 64'h1234;
        step(); #1;
        n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL rstmid_setup: mem_write got %b want 1", mem_write); end
        step();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({mem_read, mem_write, busy, grant_e, e_done, f_done} !== 6'd0 || mem_address !== 64'd0 || mem_writedata !== 64'd0) begin n_bad++; $display("FAIL rstmid_async: got %b %h %h want 0", {mem_read, mem_write, busy, grant_e, e_done, f_done}, mem_address, mem_writedata); end
        mem_done = 1'b1;
        #1;
        n_cmp++; if ({e_done, f_done, bus_error} !== 3'd0) begin n_bad++; $display("FAIL rstmid_no_done: got %b want 000", {e_done, f_done, bus_error}); end
        step();
        e_write = 1'b0; mem_done = 1'b0; reset_n = 1'b1;
        step(); #1;
        n_cmp++; if ({busy, e_done, mem_write} !== 3'd0) begin n_bad++; $display("FAIL rstmid_after: got %b want 000", {busy, e_done, mem_write}); end
    endtask

    task automatic test_edge_cases();
        apply_reset();
        e_read = 1'b1; e_write = 1'b1; e_address = 64'h40;
        step(); #1;
        n_cmp++; if ({mem_read, mem_write} !== 2'b01) begin n_bad++; $display("FAIL edge_rw_both: got %b want 01", {mem_read, mem_write}); end
        step();
        mem_done = 1'b1;
        #1;
        n_cmp++; if (e_done !== 1'b1) begin n_bad++; $display("FAIL edge_rw_done: got %b want 1", e_done); end
        step();
        e_read = 1'b0; e_write = 1'b0; mem_done = 1'b0;
        step();
        mem_done = 1'b1;
        #1;
        n_cmp++; if ({f_done, e_done, bus_error, busy} !== 4'd0) begin n_bad++; $display("FAIL edge_stray: got %b want 0000", {f_done, e_done, bus_error, busy}); end
        step(); #1;
        n_cmp++; if ({f_done, e_done, busy, mem_read, mem_write} !== 5'd0) begin n_bad++; $display("FAIL edge_stray2: got %b want 00000", {f_done, e_done, busy, mem_read, mem_write}); end
        mem_done = 1'b0;
    endtask

    // Transaction-level reference: owner, ownership age, and how many E grants
    // F has sat through since it was last served.
    task automatic test_random();
        bit          m_busy = 0, m_own_e = 0, m_rd = 0, m_wr = 0;
        logic [63:0] m_addr = '0, m_wdata = '0;
        logic [1:0]  m_size = '0;
        int          m_age = 0, m_lat = 0, m_streak = 0, age_now = 0;
        bit          fd_prev = 0, ed_prev = 0, x_fd, x_ed, x_err, pick_f;
        int          kind;
        apply_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc > 0) step();
            if (fd_prev || (!f_read && $urandom_range(3, 0) == 0)) begin
                if (!fd_prev || $urandom_range(1, 0) == 1) begin
                    f_read = 1'b1; f_address = {$urandom, $urandom}; f_datasize = 2'($urandom_range(3, 0));
                end else begin
                    f_read = 1'b0;
                end
            end
            if (ed_prev || (!(e_read || e_write) && $urandom_range(3, 0) == 0)) begin
                if (!ed_prev || $urandom_range(1, 0) == 1) begin
                    kind = $urandom_range(2, 0);
                    e_read = (kind != 1); e_write = (kind != 0);
                    e_address = {$urandom, $urandom}; e_datasize = 2'($urandom_range(3, 0));
                    e_writedata = {$urandom, $urandom};
                end else begin
                    e_read = 1'b0; e_write = 1'b0;
                end
            end
            if (m_busy && !m_own_e) f_address = {$urandom, $urandom};
            if (m_busy && m_own_e) begin
                e_address = {$urandom, $urandom}; e_writedata = {$urandom, $urandom};
            end
            if (m_busy) mem_done = (m_lat != 0) && (m_age + 1 == m_lat);
            else        mem_done = ($urandom_range(7, 0) == 0);
            #1;
            x_fd = 0; x_ed = 0; x_err = 0;
            if (m_busy) begin
                age_now = m_age + 1;
                if (mem_done || age_now == TMO) begin
                    x_ed = m_own_e; x_fd = !m_own_e; x_err = !mem_done;
                end
            end
            n_cmp++; if ({f_done, e_done, bus_error} !== {x_fd, x_ed, x_err}) begin n_bad++; $display("FAIL rand_done c%0d: got %b want %b", cyc, {f_done, e_done, bus_error}, {x_fd, x_ed, x_err}); end
            n_cmp++; if ({mem_read, mem_write, busy, grant_e, mem_datasize} !== {m_rd, m_wr, m_busy, m_own_e, m_size}) begin n_bad++; $display("FAIL rand_ctrl c%0d: got %b want %b", cyc, {mem_read, mem_write, busy, grant_e, mem_datasize}, {m_rd, m_wr, m_busy, m_own_e, m_size}); end
            n_cmp++; if ({mem_address, mem_writedata} !== {m_addr, m_wdata}) begin n_bad++; $display("FAIL rand_data c%0d: got %h %h want %h %h", cyc, mem_address, mem_writedata, m_addr, m_wdata); end
            if (m_busy) begin
                if (x_fd || x_ed) begin
                    m_busy = 0; m_rd = 0; m_wr = 0;
                end else begin
                    m_age = age_now;
                end
            end else if (e_read || e_write || f_read) begin
                pick_f = f_read && (!(e_read || e_write) || m_streak == MAXW);
                m_busy = 1; m_age = 0;
                if (pick_f) begin
                    m_own_e = 0; m_addr = f_address; m_size = f_datasize; m_wdata = '0;
                    m_rd = 1; m_wr = 0; m_streak = 0;
                end else begin
                    m_own_e = 1; m_addr = e_address; m_size = e_datasize; m_wdata = e_writedata;
                    m_wr = e_write; m_rd = !e_write;
                    m_streak = f_read ? m_streak + 1 : 0;
                end
                case ($urandom_range(9, 0))
                    0:       m_lat = 0;
                    1:       m_lat = TMO;
                    default: m_lat = $urandom_range(6, 1);
                endcase
            end
            fd_prev = x_fd; ed_prev = x_ed;
        end
        step();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid();
        test_edge_cases();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
